alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//  Initiator side of the ALU operand interface: accepts ALU commands (opcode, two signed operands, tag)
//  over a valid/ready port, buffers them in a small FIFO, drives enable/opcode/inputs of one alu instance,
//  captures its registered output after the ALU latency, returns tagged results over a valid/ready port.
//  Sits between the tensor-core instruction decode and the ALU datapath; one sequencer per ALU.
// PARAMETERS
//  DATA_WIDTH   8  operand/result width (signed two's complement); must match the ALU
//  FIFO_DEPTH   4  command FIFO entries; power of two, >= 2
//  TAG_WIDTH    4  opaque tag carried from command to response
//  ALU_LATENCY  1  cycles from the alu_enable-sampling edge to a valid alu_output; >= 1
// PORTS
//  clock        in   1           rising-edge clock
//  reset_n      in   1           asynchronous active-low reset
//  cmd_valid    in   1           command present
//  cmd_ready    out  1           FIFO can accept; = !full (registered, no path from pop)
//  cmd_opcode   in   3           000 ADD, 001 SUBTRACT, 010 MULTIPLY, others illegal
//  cmd_a        in   DATA_WIDTH  operand 1 (signed)
//  cmd_b        in   DATA_WIDTH  operand 2 (signed)
//  cmd_tag      in   TAG_WIDTH   command tag
//  alu_enable   out  1           ALU enable; one-cycle pulse per issued op
//  alu_opcode   out  3           to ALU opcode
//  alu_input1   out  DATA_WIDTH  to ALU input 1
//  alu_input2   out  DATA_WIDTH  to ALU input 2
//  alu_output   in   DATA_WIDTH  registered ALU result
//  rsp_valid    out  1           response present
//  rsp_ready    in   1           downstream accepts response
//  rsp_result   out  DATA_WIDTH  result (ALU output, unmodified)
//  rsp_tag      out  TAG_WIDTH   tag of originating command
//  rsp_error    out  1           1 = illegal opcode, result forced to 0
//  fifo_count   out  $clog2(FIFO_DEPTH)+1  queued commands
// BEHAVIOUR
//  Reset (reset_n=0, async assert, sync deassert): all outputs 0, FIFO emptied, FSM -> IDLE, cmd_ready 0
//   while in reset, 1 on first cycle after deassert. Reset mid-op abandons the in-flight command (no response).
//  FIFO push: cmd_valid & cmd_ready. Push while full is not accepted, even if a pop occurs the same cycle.
//  FSM states:
//   IDLE : if FIFO non-empty, pop head; legal opcode -> ISSUE; illegal -> RESP (result 0, error 1, ALU untouched).
//   ISSUE: alu_enable=1 for exactly this cycle; alu_opcode/alu_input1/alu_input2 = popped command -> WAIT.
//   WAIT : count ALU_LATENCY cycles after the issuing edge; on the last, capture alu_output into rsp_result
//          -> RESP. alu_opcode/inputs hold the popped values through WAIT; alu_enable=0.
//   RESP : rsp_valid=1; rsp_result/tag/error stable until rsp_valid & rsp_ready -> IDLE.
//  One command in flight at a time; throughput >= one result per ALU_LATENCY+3 cycles; responses in cmd order.
//  Outside ISSUE/WAIT, alu_opcode/alu_input1/alu_input2 keep their last values and alu_enable=0.
//  Width rule: ALU wraps to DATA_WIDTH (low bits of product/sum); sequencer neither saturates nor extends.
//  fifo_count: +1 on push, -1 on pop, unchanged when both occur in the same cycle.
//  rsp_ready held low: FSM stays in RESP; FIFO keeps accepting until full, then cmd_ready=0.
//  Response rsp_ready high on the first RESP cycle: handshake completes that cycle; the next command may
//   leave IDLE on the following cycle.
//  Note: the ALU's active-high reset is driven from !reset_n at the top level.
// TESTING
//  After reset: push ADD a=5 b=3 tag=1, rsp_ready=1 -> one alu_enable pulse, opcode 000; rsp_result=8 tag=1 err=0.
//  SUB a=-4 b=7; MUL a=16 b=9 -> rsp -11 (0xF5); 144 wraps to -112 (0x90); responses in order, tags preserved.
//  Illegal opcode 3'b111 tag=6 -> alu_enable never asserted for it; rsp_result=0, rsp_error=1, rsp_tag=6.
//  rsp_ready=0, push 6 cmds -> 1 in flight + 4 queued accepted, cmd_ready=0 at count 4, 6th stalls; release -> all 5 in order.
//  Drop reset_n during WAIT of ADD 1+1 -> all outputs 0 immediately, no response after release; next cmd works.
//  Random legal ops/operands with random rsp_ready backpressure vs. model -> exact match, no loss or duplication.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Command-side sequencer for one ALU: queues tagged commands, issues them one at a time,
// and returns the captured ALU result (or an illegal-opcode error) over a valid/ready port.
module alu_op_sequencer #(
    parameter int DATA_WIDTH  = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int TAG_WIDTH   = 4,
    parameter int ALU_LATENCY = 1
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [2:0]                    cmd_opcode,
    input  logic signed [DATA_WIDTH-1:0]  cmd_a,
    input  logic signed [DATA_WIDTH-1:0]  cmd_b,
    input  logic [TAG_WIDTH-1:0]          cmd_tag,
    output logic                          alu_enable,
    output logic [2:0]                    alu_opcode,
    output logic signed [DATA_WIDTH-1:0]  alu_input1,
    output logic signed [DATA_WIDTH-1:0]  alu_input2,
    input  logic signed [DATA_WIDTH-1:0]  alu_output,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic signed [DATA_WIDTH-1:0]  rsp_result,
    output logic [TAG_WIDTH-1:0]          rsp_tag,
    output logic                          rsp_error,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int WCNT_W  = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;
    localparam int ENTRY_W = 3 + 2 * DATA_WIDTH + TAG_WIDTH;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                         state, state_nxt;
    logic [ENTRY_W-1:0]             mem [FIFO_DEPTH];
    logic [PTR_W-1:0]               wr_ptr, rd_ptr;
    logic [CNT_W-1:0]               count_nxt;
    logic [WCNT_W-1:0]              wait_cnt;
    logic                           push, pop, wait_last, head_legal;
    logic [ENTRY_W-1:0]             head;
    logic [2:0]                     head_op;
    logic signed [DATA_WIDTH-1:0]   head_a, head_b;
    logic [TAG_WIDTH-1:0]           head_tag;

    assign push       = cmd_valid & cmd_ready;
    assign pop        = (state == IDLE) && (fifo_count != '0);
    assign head       = mem[rd_ptr];
    assign head_op    = head[ENTRY_W-1 -: 3];
    assign head_a     = head[TAG_WIDTH+2*DATA_WIDTH-1 -: DATA_WIDTH];
    assign head_b     = head[TAG_WIDTH+DATA_WIDTH-1 -: DATA_WIDTH];
    assign head_tag   = head[TAG_WIDTH-1:0];
    assign head_legal = (head_op <= 3'd2);
    assign wait_last  = (wait_cnt == WCNT_W'(ALU_LATENCY - 1));

    always_comb begin
        count_nxt = fifo_count;
        case ({push, pop})
            2'b10:   count_nxt = fifo_count + 1'b1;
            2'b01:   count_nxt = fifo_count - 1'b1;
            default: count_nxt = fifo_count;
        endcase
    end

    // cmd_ready is registered from the next occupancy so a same-cycle pop never frees a full FIFO
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            cmd_ready  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            fifo_count <= count_nxt;
            cmd_ready  <= (count_nxt != CNT_W'(FIFO_DEPTH));
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= {cmd_opcode, cmd_a, cmd_b, cmd_tag};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (fifo_count != '0) state_nxt = head_legal ? ISSUE : RESP;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (wait_last) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        alu_enable = (state == ISSUE);
        rsp_valid  = (state == RESP);
    end

    // Illegal opcodes never reach the ALU: the response is formed directly at pop time
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt   <= '0;
            alu_opcode <= '0;
            alu_input1 <= '0;
            alu_input2 <= '0;
            rsp_result <= '0;
            rsp_tag    <= '0;
            rsp_error  <= 1'b0;
        end else begin
            if (state == ISSUE)     wait_cnt <= '0;
            else if (state == WAIT) wait_cnt <= wait_cnt + 1'b1;
            if (pop) begin
                rsp_tag <= head_tag;
                if (head_legal) begin
                    alu_opcode <= head_op;
                    alu_input1 <= head_a;
                    alu_input2 <= head_b;
                end else begin
                    rsp_result <= '0;
                    rsp_error  <= 1'b1;
                end
            end
            if (state == WAIT && wait_last) begin
                rsp_result <= alu_output;
                rsp_error  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural one-cycle registered ALU attached.
module tb_alu_op_sequencer;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_opcode = '0;
    logic [7:0] cmd_a = '0, cmd_b = '0;
    logic [3:0] cmd_tag = '0;
    logic       alu_enable;
    logic [2:0] alu_opcode;
    logic [7:0] alu_input1, alu_input2, alu_output;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_result;
    logic [3:0] rsp_tag;
    logic       rsp_error;
    logic [2:0] fifo_count;

    int passed = 0, total = 0, fails = 0;
    int en_count = 0, en0 = 0;
    logic [11:0] expq [$];
    logic [11:0] ex;
    logic [15:0] prod;
    logic [7:0]  mres;
    logic        acc, seen;
    int          sent, got;
    localparam int NR = 24;

    always #5 clock = ~clock;

    alu_op_sequencer dut (
        .clock(clock), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
        .alu_enable(alu_enable), .alu_opcode(alu_opcode),
        .alu_input1(alu_input1), .alu_input2(alu_input2), .alu_output(alu_output),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_tag(rsp_tag), .rsp_error(rsp_error), .fifo_count(fifo_count)
    );

    // Registered ALU model, reset from !reset_n
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) alu_output <= '0;
        else if (alu_enable) begin
            case (alu_opcode)
                3'd0:    alu_output <= alu_input1 + alu_input2;
                3'd1:    alu_output <= alu_input1 - alu_input2;
                3'd2:    alu_output <= 8'(alu_input1 * alu_input2);
                default: alu_output <= alu_output;
            endcase
        end
    end

    always @(posedge clock) if (alu_enable) en_count <= en_count + 1;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic push(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] tag, input int max_cyc, output logic ok);
        cmd_opcode = op; cmd_a = a; cmd_b = b; cmd_tag = tag; cmd_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < max_cyc && !ok; i++) begin
            if (cmd_ready) ok = 1'b1;
            @(negedge clock);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic get_rsp(input string name, input logic [7:0] res, input logic [3:0] tag, input logic err);
        rsp_ready = 1'b1;
        for (int i = 0; i < 50 && !rsp_valid; i++) @(negedge clock);
        chk({name, "_valid"}, 32'(rsp_valid), 32'd1);
        chk({name, "_result"}, 32'(rsp_result), 32'(res));
        chk({name, "_tag"}, 32'(rsp_tag), 32'(tag));
        chk({name, "_error"}, 32'(rsp_error), 32'(err));
        @(negedge clock);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clock);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_alu_enable", 32'(alu_enable), 32'd0);
        chk("rst_fifo_count", 32'(fifo_count), 32'd0);
        chk("rst_rsp_result", 32'(rsp_result), 32'd0);
        reset_n = 1'b1;
        @(negedge clock);
        chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

        // ADD 5+3
        en0 = en_count;
        push(3'd0, 8'd5, 8'd3, 4'd1, 20, acc);
        chk("add_accept", 32'(acc), 32'd1);
        get_rsp("add", 8'd8, 4'd1, 1'b0);
        chk("add_en_pulses", 32'(en_count - en0), 32'd1);
        chk("add_alu_opcode", 32'(alu_opcode), 32'd0);
        chk("add_alu_in1", 32'(alu_input1), 32'd5);
        chk("add_alu_in2", 32'(alu_input2), 32'd3);

        // SUB then MUL, queued back to back, with wrap
        rsp_ready = 1'b0;
        push(3'd1, 8'hFC, 8'd7, 4'd2, 20, acc);
        push(3'd2, 8'd16, 8'd9, 4'd3, 20, acc);
        get_rsp("sub", 8'hF5, 4'd2, 1'b0);
        get_rsp("mul", 8'h90, 4'd3, 1'b0);
        chk("mul_alu_opcode", 32'(alu_opcode), 32'd2);
        chk("mul_alu_in1", 32'(alu_input1), 32'd16);

        // Illegal opcode never touches the ALU
        en0 = en_count;
        push(3'd7, 8'd9, 8'd9, 4'd6, 20, acc);
        get_rsp("illegal", 8'd0, 4'd6, 1'b1);
        chk("illegal_no_enable", 32'(en_count - en0), 32'd0);
        chk("illegal_alu_held", 32'(alu_opcode), 32'd2);

        // Backpressure: 1 in flight + 4 queued, 6th stalls
        rsp_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            push(3'd0, 8'(i), 8'(i), 4'(7 + i), 20, acc);
            chk("bp_accept", 32'(acc), 32'd1);
        end
        chk("bp_count_full", 32'(fifo_count), 32'd4);
        chk("bp_ready_low", 32'(cmd_ready), 32'd0);
        push(3'd0, 8'd6, 8'd6, 4'd13, 8, acc);
        chk("bp_sixth_stalled", 32'(acc), 32'd0);
        chk("bp_count_held", 32'(fifo_count), 32'd4);
        chk("bp_rsp_held_tag", 32'(rsp_tag), 32'd8);
        for (int i = 1; i <= 5; i++) get_rsp("bp", 8'(2 * i), 4'(7 + i), 1'b0);
        chk("bp_drained", 32'(fifo_count), 32'd0);

        // Reset during WAIT abandons the command
        rsp_ready = 1'b0;
        push(3'd0, 8'd1, 8'd1, 4'd14, 20, acc);
        @(negedge clock);
        chk("mid_issue_enable", 32'(alu_enable), 32'd1);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_in1", 32'(alu_input1), 32'd0);
        chk("mid_rst_opcode", 32'(alu_opcode), 32'd0);
        chk("mid_rst_enable", 32'(alu_enable), 32'd0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_ready", 32'(cmd_ready), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        rsp_ready = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clock);
            if (rsp_valid) seen = 1'b1;
        end
        chk("mid_rst_no_rsp", 32'(seen), 32'd0);
        push(3'd1, 8'd20, 8'd5, 4'd15, 20, acc);
        get_rsp("after_rst", 8'd15, 4'd15, 1'b0);

        // Random legal traffic with random backpressure against an in-order model
        sent = 0; got = 0; acc = 1'b0;
        for (int cyc = 0; cyc < 3000 && got < NR; cyc++) begin
            if (acc) cmd_valid = 1'b0;
            acc = 1'b0;
            if (!cmd_valid && sent < NR && $urandom_range(0, 3) != 0) begin
                cmd_opcode = 3'($urandom_range(0, 2));
                cmd_a = 8'($urandom);
                cmd_b = 8'($urandom);
                cmd_tag = 4'(sent);
                cmd_valid = 1'b1;
            end
            rsp_ready = ($urandom_range(0, 2) != 0);
            if (rsp_valid && rsp_ready) begin
                if (expq.size() == 0) chk("rnd_extra_rsp", 32'(rsp_valid), 32'd0);
                else begin
                    ex = expq.pop_front();
                    chk("rnd_result", 32'(rsp_result), 32'(ex[7:0]));
                    chk("rnd_tag", 32'(rsp_tag), 32'(ex[11:8]));
                    got++;
                end
            end
            if (cmd_valid && cmd_ready) begin
                prod = cmd_a * cmd_b;
                case (cmd_opcode)
                    3'd0:    mres = cmd_a + cmd_b;
                    3'd1:    mres = cmd_a - cmd_b;
                    default: mres = prod[7:0];
                endcase
                expq.push_back({cmd_tag, mres});
                sent++;
                acc = 1'b1;
            end
            @(negedge clock);
        end
        cmd_valid = 1'b0;
        chk("rnd_all_received", 32'(got), 32'(NR));
        chk("rnd_queue_empty", 32'(expq.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
